// File: rtl/fetch_align_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoder-facing
// instruction port, branch redirect and halt status.
interface fetch_align_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_pc;
  logic [2:0]  ir_len;
  logic        ir_illegal;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halted;

  modport master (
    output mem_req, mem_addr, ir, ir_valid, ir_pc, ir_len, ir_illegal, halted,
    input  mem_ack, mem_rdata, ir_ready, br_taken, br_target
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_valid, ir_pc, ir_len, ir_illegal, halted,
    output mem_ack, mem_rdata, ir_ready, br_taken, br_target
  );
endinterface

// File: rtl/fetch_align.sv
// Instruction fetch/align stage: prefetches 32-bit words into a byte queue,
// sizes each variable-length instruction from its opcode byte and presents it
// to the decoder with its PC. Handles branch redirect and HLT.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 8
) (
  input logic           clk,
  input logic           rst_n,
  fetch_align_if.master bus
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DISCARD} fstate_t;

  fstate_t       fstate, fstate_n;
  logic [7:0]    q [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic [31:0]   fpc, dpc, disc_addr, mem_addr_w;

  logic [31:0]   ir_q, ir_pc_q;
  logic [2:0]    ir_len_q;
  logic          ir_valid_q, ir_ill_q, halted_q;

  logic [7:0]    hd [4];
  logic [7:0]    push_byte [4];
  logic [2:0]    head_len, push_cnt, pop_cnt;
  logic          head_ill, load, push, ack, halt_now, want_req;
  logic [31:0]   ir_next;

  function automatic logic [2:0] op_len(input logic [7:0] op);
    case (op)
      8'h8B, 8'h89, 8'h01, 8'h29, 8'h39,
      8'h21, 8'h09, 8'h31, 8'hF7:        op_len = 3'd2;
      8'h83, 8'hC1, 8'h90:               op_len = 3'd3;
      8'h66:                             op_len = 3'd4;
      default:                           op_len = 3'd1;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [7:0] op);
    case (op)
      8'h8B, 8'h89, 8'h01, 8'h29, 8'h39, 8'h21, 8'h09, 8'h31, 8'hF7,
      8'h83, 8'hC1, 8'h90, 8'h66, 8'hF4: op_illegal = 1'b0;
      default:                           op_illegal = 1'b1;
    endcase
  endfunction

  // Queue head window and byte lanes of the returning word, rotated by fpc offset
  always_comb begin
    logic [1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      hd[i]        = q[rd_ptr + AW'(i)];
      sel          = fpc[1:0] + 2'(i);
      push_byte[i] = bus.mem_rdata[{sel, 3'b000} +: 8];
    end
  end

  // Issue/push decisions and next queue occupancy; redirect overrides both
  always_comb begin
    head_len = op_len(hd[0]);
    head_ill = op_illegal(hd[0]);
    ack      = (fstate != F_IDLE) && bus.mem_ack;
    load     = (!ir_valid_q || bus.ir_ready) && (count != '0) &&
               (count >= CW'(head_len)) && !halted_q && !bus.br_taken;
    push     = ack && (fstate == F_WAIT) && !halted_q && !bus.br_taken;
    push_cnt = push ? (3'd4 - {1'b0, fpc[1:0]}) : 3'd0;
    pop_cnt  = load ? head_len : 3'd0;
    halt_now = load && (hd[0] == 8'hF4);
    count_n  = bus.br_taken ? '0 : (count + CW'(push_cnt) - CW'(pop_cnt));
    want_req = !(halted_q || halt_now) && (count_n <= CW'(QDEPTH - 4));
    ir_next  = {hd[0],
                (head_len >= 3'd2) ? hd[1] : 8'h00,
                (head_len >= 3'd3) ? hd[2] : 8'h00,
                (head_len >= 3'd4) ? hd[3] : 8'h00};
    mem_addr_w = (fstate == F_DISCARD) ? disc_addr : {fpc[31:2], 2'b00};
  end

  // Fetch FSM next state: one outstanding read; redirect mid-read marks it for discard
  always_comb begin
    fstate_n = fstate;
    unique case (fstate)
      F_IDLE:    fstate_n = want_req ? F_WAIT : F_IDLE;
      F_WAIT: begin
        if (bus.mem_ack)       fstate_n = want_req ? F_WAIT : F_IDLE;
        else if (bus.br_taken) fstate_n = F_DISCARD;
      end
      F_DISCARD: if (bus.mem_ack) fstate_n = want_req ? F_WAIT : F_IDLE;
      default:   fstate_n = F_IDLE;
    endcase
  end

  // Fetch FSM state, fetch PC and the address held for a discarded read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate    <= F_IDLE;
      fpc       <= RESET_PC;
      disc_addr <= '0;
    end else begin
      fstate <= fstate_n;
      if (fstate_n == F_DISCARD) disc_addr <= mem_addr_w;
      if (bus.br_taken)                    fpc <= bus.br_target;
      else if (ack && fstate == F_WAIT)    fpc <= {fpc[31:2] + 30'd1, 2'b00};
    end
  end

  // Byte queue storage; only written by accepted fetch data
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < push_cnt) q[wr_ptr + AW'(i)] <= push_byte[i];
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_n;
      if (bus.br_taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + AW'(pop_cnt);
        wr_ptr <= wr_ptr + AW'(push_cnt);
      end
    end
  end

  // Instruction register, decode PC and halt flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
      ir_len_q   <= '0;
      ir_ill_q   <= 1'b0;
      halted_q   <= 1'b0;
      dpc        <= RESET_PC;
    end else begin
      if (halt_now) halted_q <= 1'b1;
      if (bus.br_taken) begin
        ir_valid_q <= 1'b0;
        dpc        <= bus.br_target;
      end else if (load) begin
        ir_q       <= ir_next;
        ir_pc_q    <= dpc;
        ir_len_q   <= head_len;
        ir_ill_q   <= head_ill;
        ir_valid_q <= 1'b1;
        dpc        <= dpc + 32'(head_len);
      end else if (bus.ir_ready) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign bus.mem_req    = (fstate != F_IDLE);
  assign bus.mem_addr   = mem_addr_w;
  assign bus.ir         = ir_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.ir_pc      = ir_pc_q;
  assign bus.ir_len     = ir_len_q;
  assign bus.ir_illegal = ir_ill_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: directed programs in a byte memory model,
// expected instructions queued by the stimulus and checked by a monitor.
module tb_fetch_align;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_align_if bus ();

  fetch_align #(.RESET_PC(32'h0000_0000), .QDEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [2:0]  len;
    logic        ill;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  mem [logic [31:0]];
  logic        mem_stall = 1'b0;
  int          lat = 0;
  int          wcnt = 0;

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic expect_ir(input logic [31:0] ir, input logic [31:0] pc,
                           input logic [2:0] len, input logic ill);
    exp_t e;
    e.ir = ir; e.pc = pc; e.len = len; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Memory responder: acks lat cycles after a request unless stalled
  always @(negedge clk) begin
    if (bus.mem_req && !mem_stall && wcnt >= lat) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = {rdb({bus.mem_addr[31:2], 2'b11}), rdb({bus.mem_addr[31:2], 2'b10}),
                       rdb({bus.mem_addr[31:2], 2'b01}), rdb({bus.mem_addr[31:2], 2'b00})};
      wcnt = 0;
    end else begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) wcnt++;
      else wcnt = 0;
    end
  end

  // Monitor: every accepted instruction is popped and compared
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ir_valid && bus.ir_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL ir_unexpected: got ir=%h pc=%h len=%0d, required no instruction",
                 bus.ir, bus.ir_pc, bus.ir_len);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.ir === mon_e.ir && bus.ir_pc === mon_e.pc &&
            bus.ir_len === mon_e.len && bus.ir_illegal === mon_e.ill)
          n_pass++;
        else
          $display("FAIL ir_seq: got ir=%h pc=%h len=%0d ill=%b, required ir=%h pc=%h len=%0d ill=%b",
                   bus.ir, bus.ir_pc, bus.ir_len, bus.ir_illegal,
                   mon_e.ir, mon_e.pc, mon_e.len, mon_e.ill);
      end
    end
  end

  // Reset, park a stalled request, then redirect to the program under test
  task automatic go(input logic [31:0] tgt);
    bus.ir_ready = 1'b0;
    mem_stall = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.br_taken = 1'b1; bus.br_target = tgt;
    @(posedge clk);
    #1 bus.br_taken = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},    32'(bus.mem_req),    0);
    chk({tag, "_ir"},         bus.ir,              0);
    chk({tag, "_ir_valid"},   32'(bus.ir_valid),   0);
    chk({tag, "_ir_pc"},      bus.ir_pc,           0);
    chk({tag, "_ir_len"},     32'(bus.ir_len),     0);
    chk({tag, "_ir_illegal"}, 32'(bus.ir_illegal), 0);
    chk({tag, "_halted"},     32'(bus.halted),     0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got time limit reached, required run completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    int bad, early, seen, run, done;
    logic [31:0] held;

    rst_n = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus.ir_ready = 1'b1; bus.br_taken = 1'b0; bus.br_target = '0;
    #1;
    chk_reset_outputs("rst0");
    chk("rst0_mem_addr", bus.mem_addr, 32'h0);

    // Program 1: 01 C0 | 00 | 00 | F4 from RESET_PC, ready held high
    poke(32'h0, 8'h01); poke(32'h1, 8'hC0); poke(32'h2, 8'h00); poke(32'h3, 8'h00);
    poke(32'h4, 8'hF4); poke(32'h5, 8'h77); poke(32'h6, 8'h88); poke(32'h7, 8'h99);
    expect_ir(32'h01C0_0000, 32'h0, 3'd2, 1'b0);
    expect_ir(32'h0000_0000, 32'h2, 3'd1, 1'b1);
    expect_ir(32'h0000_0000, 32'h3, 3'd1, 1'b1);
    expect_ir(32'hF400_0000, 32'h4, 3'd1, 1'b0);
    #11 rst_n = 1'b1;
    drain("p1_drain");
    chk("p1_halted", 32'(bus.halted), 1);
    bad = 0;
    repeat (6) begin @(negedge clk); if (bus.mem_req || bus.ir_valid) bad++; end
    chk("p1_quiet_after_halt", bad, 0);

    // Wrap: 4-byte op straddling 0xFFFFFFFF -> 0x0
    poke(32'hFFFF_FFFE, 8'h66); poke(32'hFFFF_FFFF, 8'h11);
    go(32'hFFFF_FFFE);
    expect_ir(32'h6611_01C0, 32'hFFFF_FFFE, 3'd4, 1'b0);
    expect_ir(32'h0000_0000, 32'h2, 3'd1, 1'b1);
    expect_ir(32'h0000_0000, 32'h3, 3'd1, 1'b1);
    expect_ir(32'hF400_0000, 32'h4, 3'd1, 1'b0);
    bus.ir_ready = 1'b1;
    drain("wrap_drain");

    // Straddle: 83 E8 05 across the 0x204 word boundary, slow memory
    poke(32'h200, 8'hAA); poke(32'h201, 8'hBB); poke(32'h202, 8'h83); poke(32'h203, 8'hE8);
    poke(32'h204, 8'h05); poke(32'h205, 8'hF4);
    lat = 2;
    go(32'h202);
    expect_ir(32'h83E8_0500, 32'h202, 3'd3, 1'b0);
    expect_ir(32'hF400_0000, 32'h205, 3'd1, 1'b0);
    bus.ir_ready = 1'b1;
    early = 0; seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req && bus.mem_ack && bus.mem_addr == 32'h204) seen = 1;
      else if (bus.ir_valid) early = 1;
    end
    chk("straddle_ack_seen", seen, 1);
    chk("straddle_no_partial", early, 0);
    drain("straddle_drain");
    lat = 0;

    // Redirect with a read outstanding: ack data at 0x0 must be dropped
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h89);
    poke(32'h104, 8'h05); poke(32'h105, 8'h90); poke(32'h106, 8'hAA); poke(32'h107, 8'hBB);
    poke(32'h108, 8'hF4);
    bus.ir_ready = 1'b0; mem_stall = 1'b1; exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("redir_pending", {bus.mem_addr[30:0], bus.mem_req}, 32'h1);
    bus.br_taken = 1'b1; bus.br_target = 32'h103;
    @(posedge clk); #1 bus.br_taken = 1'b0;
    chk("redir_addr_held", {bus.mem_addr[30:0], bus.mem_req}, 32'h1);
    mem_stall = 1'b0;
    @(posedge clk); #1;
    chk("redir_new_addr", bus.mem_addr, 32'h100);
    chk("redir_new_req", 32'(bus.mem_req), 1);
    expect_ir(32'h8905_0000, 32'h103, 3'd2, 1'b0);
    expect_ir(32'h90AA_BB00, 32'h105, 3'd3, 1'b0);
    expect_ir(32'hF400_0000, 32'h108, 3'd1, 1'b0);
    bus.ir_ready = 1'b1;
    drain("redir_drain");
    chk("redir_halted", 32'(bus.halted), 1);

    // Backpressure: ready low while memory acks every cycle
    for (int i = 0; i < 8; i++) begin
      poke(32'h300 + 32'(2 * i), 8'h8B);
      poke(32'h301 + 32'(2 * i), 8'(i + 1));
    end
    poke(32'h310, 8'hF4);
    go(32'h300);
    for (int i = 0; i < 8; i++)
      expect_ir({8'h8B, 8'(i + 1), 16'h0}, 32'h300 + 32'(2 * i), 3'd2, 1'b0);
    expect_ir(32'hF400_0000, 32'h310, 3'd1, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk); if (bus.ir_valid) seen = 1;
    end
    chk("bp_first_valid", seen, 1);
    held = bus.ir;
    bad = 0;
    repeat (10) begin @(negedge clk); if (!bus.ir_valid || bus.ir !== held) bad++; end
    chk("bp_ir_stable", bad, 0);
    chk("bp_held_value", held, 32'h8B01_0000);
    chk("bp_full_no_req", 32'(bus.mem_req), 0);
    @(posedge clk); #1 bus.ir_ready = 1'b1;
    drain("bp_drain");

    // Throughput: nine instructions back-to-back, one per cycle
    poke(32'h400, 8'h01); poke(32'h401, 8'hAA); poke(32'h402, 8'h29); poke(32'h403, 8'hBB);
    poke(32'h404, 8'h39); poke(32'h405, 8'hCC); poke(32'h406, 8'h09); poke(32'h407, 8'hDD);
    poke(32'h408, 8'h31); poke(32'h409, 8'hEE); poke(32'h40A, 8'hF7); poke(32'h40B, 8'hFF);
    poke(32'h40C, 8'h8B); poke(32'h40D, 8'h12); poke(32'h40E, 8'h89); poke(32'h40F, 8'h34);
    poke(32'h410, 8'hF4);
    go(32'h400);
    expect_ir(32'h01AA_0000, 32'h400, 3'd2, 1'b0);
    expect_ir(32'h29BB_0000, 32'h402, 3'd2, 1'b0);
    expect_ir(32'h39CC_0000, 32'h404, 3'd2, 1'b0);
    expect_ir(32'h09DD_0000, 32'h406, 3'd2, 1'b0);
    expect_ir(32'h31EE_0000, 32'h408, 3'd2, 1'b0);
    expect_ir(32'hF7FF_0000, 32'h40A, 3'd2, 1'b0);
    expect_ir(32'h8B12_0000, 32'h40C, 3'd2, 1'b0);
    expect_ir(32'h8934_0000, 32'h40E, 3'd2, 1'b0);
    expect_ir(32'hF400_0000, 32'h410, 3'd1, 1'b0);
    bus.ir_ready = 1'b1;
    run = 0; done = 0;
    for (int i = 0; i < 60 && done == 0; i++) begin
      @(negedge clk); #1;
      if (bus.ir_valid) run++;
      else if (run > 0) done = 1;
    end
    chk("tput_run", run, 9);
    drain("tput_drain");

    // Async reset mid-stream, mid-cycle
    for (int i = 0; i < 16; i++) begin
      poke(32'h500 + 32'(2 * i), 8'h8B);
      poke(32'h501 + 32'(2 * i), 8'(8'h40 + i));
    end
    go(32'h500);
    for (int i = 0; i < 16; i++)
      expect_ir({8'h8B, 8'(8'h40 + i), 16'h0}, 32'h500 + 32'(2 * i), 3'd2, 1'b0);
    bus.ir_ready = 1'b1;
    repeat (5) @(posedge clk);
    #3 exp_q.delete();
    rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    bus.ir_ready = 1'b0;
    #2 rst_n = 1'b1;
    #1 chk("arst_mem_addr_idle", bus.mem_addr, 32'h0);
    @(posedge clk); #1;
    chk("arst_first_req", {bus.mem_addr[30:0], bus.mem_req}, 32'h1);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
